// File: rtl/alu_exec_sequencer_pkg.sv
// Shared constants, instruction layout, FSM states and helpers for the
// multi-cycle ALU execute sequencer.
package alu_exec_sequencer_pkg;

  localparam int unsigned DW   = 16;
  localparam int unsigned NREG = 8;
  localparam int unsigned RW   = 3;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  // op field under OPC_MOV
  localparam logic [1:0] OP_MOVR = 2'b00;
  localparam logic [1:0] OP_MOVI = 2'b10;

  // op field under OPC_ALU, driven straight onto the ALU op port
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_CMP = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MVN = 2'b11;

  localparam logic [1:0] SH_PASS = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  localparam int unsigned ST_Z = 0;
  localparam int unsigned ST_N = 1;
  localparam int unsigned ST_V = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    LOAD_A = 3'd2,
    LOAD_B = 3'd3,
    EXEC   = 3'd4,
    WB     = 3'd5,
    WB_IMM = 3'd6,
    ERR    = 3'd7
  } state_e;

  typedef struct packed {
    logic [2:0]    opcode;
    logic [1:0]    op;
    logic [RW-1:0] rn;
    logic [RW-1:0] rd;
    logic [1:0]    sh;
    logic [RW-1:0] rm;
  } instr_t;

  function automatic logic [DW-1:0] shift_b(input logic [DW-1:0] b, input logic [1:0] sh);
    logic [DW-1:0] res;
    res = b;
    case (sh)
      SH_PASS: res = b;
      SH_LSL:  res = {b[DW-2:0], 1'b0};
      SH_LSR:  res = {1'b0, b[DW-1:1]};
      SH_ASR:  res = {b[DW-1], b[DW-1:1]};
      default: res = b;
    endcase
    return res;
  endfunction

  function automatic logic [DW-1:0] sext8(input logic [7:0] imm);
    return {{(DW-8){imm[7]}}, imm};
  endfunction

endpackage

// File: rtl/alu_exec_sequencer_regfile8x16.sv
// 8x16 register file: one write port, two operand read ports and a debug
// read port, all reads combinational; async active-low clear.
module alu_exec_sequencer_regfile8x16
  import alu_exec_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [RW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [RW-1:0] i_ra_addr,
  input  logic [RW-1:0] i_rb_addr,
  input  logic [RW-1:0] i_dbg_addr,
  output logic [DW-1:0] o_ra_data,
  output logic [DW-1:0] o_rb_data,
  output logic [DW-1:0] o_dbg_data
);

  logic [DW-1:0] r_mem [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_ra_data  = r_mem[i_ra_addr];
  assign o_rb_data  = r_mem[i_rb_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_exec_sequencer.sv
// Multi-cycle execute stage: fetches operands from the register file, drives
// an external 16-bit ALU, captures result/flags and writes the result back.
module alu_exec_sequencer
  import alu_exec_sequencer_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [DW-1:0] instr,
  output logic [DW-1:0] alu_ain,
  output logic [DW-1:0] alu_bin,
  output logic [1:0]    alu_op,
  input  logic [DW-1:0] alu_out,
  input  logic [2:0]    alu_z,
  output logic [DW-1:0] result,
  output logic [2:0]    status,
  output logic          done,
  output logic          err,
  input  logic [RW-1:0] dbg_sel,
  output logic [DW-1:0] dbg_data
);

  state_e        r_state;
  state_e        w_next;
  instr_t        r_ir;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_c;
  logic [2:0]    r_status;
  logic          r_ready;
  logic          r_done;
  logic          r_err;
  logic [DW-1:0] r_alu_ain;
  logic [DW-1:0] r_alu_bin;
  logic [1:0]    r_alu_op;

  logic          w_is_movi;
  logic          w_is_mov;
  logic          w_is_alu;
  logic          w_is_cmp;
  logic [7:0]    w_imm8;
  logic          w_we;
  logic [RW-1:0] w_waddr;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rd_a;
  logic [DW-1:0] w_rd_b;

  // Decode of the latched instruction word
  assign w_imm8    = {r_ir.rd, r_ir.sh, r_ir.rm};
  assign w_is_movi = (r_ir.opcode == OPC_MOV) && (r_ir.op == OP_MOVI);
  assign w_is_mov  = (r_ir.opcode == OPC_MOV) && (r_ir.op == OP_MOVR);
  assign w_is_alu  = (r_ir.opcode == OPC_ALU) &&
                     (r_ir.op inside {OP_ADD, OP_CMP, OP_AND, OP_MVN});
  assign w_is_cmp  = w_is_alu && (r_ir.op == OP_CMP);

  alu_exec_sequencer_regfile8x16 u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (w_we),
    .i_waddr    (w_waddr),
    .i_wdata    (w_wdata),
    .i_ra_addr  (r_ir.rn),
    .i_rb_addr  (r_ir.rm),
    .i_dbg_addr (dbg_sel),
    .o_ra_data  (w_rd_a),
    .o_rb_data  (w_rd_b),
    .o_dbg_data (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next state and register-file write port
  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_waddr = r_ir.rd;
    w_wdata = r_c;
    case (r_state)
      IDLE:   if (instr_valid) w_next = DECODE;
      DECODE: begin
        if (w_is_movi)                 w_next = WB_IMM;
        else if (w_is_mov || w_is_alu) w_next = LOAD_A;
        else                           w_next = ERR;
      end
      LOAD_A: w_next = LOAD_B;
      LOAD_B: w_next = EXEC;
      EXEC:   w_next = WB;
      WB: begin
        w_next = IDLE;
        w_we   = !w_is_cmp;
      end
      WB_IMM: begin
        w_next  = IDLE;
        w_we    = 1'b1;
        w_waddr = r_ir.rn;
        w_wdata = sext8(w_imm8);
      end
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Moore handshake/pulse outputs, registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= (w_next == IDLE);
      r_done  <= (w_next == WB) || (w_next == WB_IMM) || (w_next == ERR);
      r_err   <= (w_next == ERR);
    end
  end

  // Datapath holding registers; the B operand is stored already shifted in
  // r_alu_bin, which is only non-zero while the FSM sits in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir      <= '0;
      r_a       <= '0;
      r_c       <= '0;
      r_status  <= '0;
      r_alu_ain <= '0;
      r_alu_bin <= '0;
      r_alu_op  <= '0;
    end else begin
      if ((r_state == IDLE) && instr_valid) r_ir <= instr;
      if (r_state == LOAD_A) r_a <= w_rd_a;
      if (r_state == LOAD_B) begin
        r_alu_ain <= w_is_alu ? r_a : '0;
        r_alu_bin <= shift_b(w_rd_b, r_ir.sh);
        r_alu_op  <= w_is_alu ? r_ir.op : 2'b00;
      end else begin
        r_alu_ain <= '0;
        r_alu_bin <= '0;
        r_alu_op  <= 2'b00;
      end
      if (r_state == EXEC) begin
        r_c            <= alu_out;
        r_status[ST_Z] <= alu_z[ST_Z];
        r_status[ST_N] <= alu_z[ST_N];
        r_status[ST_V] <= alu_z[ST_V];
      end
    end
  end

  assign instr_ready = r_ready;
  assign done        = r_done;
  assign err         = r_err;
  assign result      = r_c;
  assign status      = r_status;
  assign alu_ain     = r_alu_ain;
  assign alu_bin     = r_alu_bin;
  assign alu_op      = r_alu_op;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Randomized self-checking bench for alu_exec_sequencer with a behavioural
// ALU and an architectural reference model of the register file and flags.
module tb_alu_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = 16'h0;
  logic [15:0] alu_ain, alu_bin, alu_out;
  logic [1:0]  alu_op;
  logic [2:0]  alu_z;
  logic [15:0] result;
  logic [2:0]  status;
  logic        done, err;
  logic [2:0]  dbg_sel = 3'd0;
  logic [15:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_reg [8];
  logic [15:0] m_c;
  logic [2:0]  m_status;

  alu_exec_sequencer dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_ain(alu_ain), .alu_bin(alu_bin), .alu_op(alu_op),
    .alu_out(alu_out), .alu_z(alu_z), .result(result), .status(status),
    .done(done), .err(err), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // External 16-bit ALU
  always_comb begin
    alu_out = 16'h0;
    case (alu_op)
      2'b00:   alu_out = alu_ain + alu_bin;
      2'b01:   alu_out = alu_ain - alu_bin;
      2'b10:   alu_out = alu_ain & alu_bin;
      default: alu_out = ~alu_bin;
    endcase
    alu_z[0] = (alu_out == 16'h0);
    alu_z[1] = alu_out[15];
    alu_z[2] = 1'b0;
    if (alu_op == 2'b00)
      alu_z[2] = (alu_ain[15] == alu_bin[15]) && (alu_out[15] != alu_ain[15]);
    else if (alu_op == 2'b01)
      alu_z[2] = (alu_ain[15] != alu_bin[15]) && (alu_out[15] != alu_ain[15]);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_shift(input logic [15:0] b, input logic [1:0] sh);
    logic signed [15:0] sb;
    sb = $signed(b);
    case (sh)
      2'd0:    return b;
      2'd1:    return 16'(b * 2);
      2'd2:    return b / 2;
      default: return 16'(sb >>> 1);
    endcase
  endfunction

  // Architectural effect of one instruction; returns expected latency/err
  task automatic model_apply(input logic [15:0] w, output int lat, output bit e);
    logic [2:0]  opc, rn, rd, rm;
    logic [1:0]  op, sh, aop;
    logic [15:0] a, b, res;
    int          sa, sb, full;
    bit          v;
    opc = w[15:13]; op = w[12:11]; rn = w[10:8]; rd = w[7:5]; sh = w[4:3]; rm = w[2:0];
    e = 1'b0;
    if (opc == 3'b110 && op == 2'b10) begin
      m_reg[rn] = {{8{w[7]}}, w[7:0]};
      lat = 2;
    end else if ((opc == 3'b110 && op == 2'b00) || opc == 3'b101) begin
      a   = (opc == 3'b101) ? m_reg[rn] : 16'h0;
      b   = m_shift(m_reg[rm], sh);
      aop = (opc == 3'b101) ? op : 2'b00;
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      v   = 1'b0;
      case (aop)
        2'd0: begin full = sa + sb; v = (full > 32767) || (full < -32768); end
        2'd1: begin full = sa - sb; v = (full > 32767) || (full < -32768); end
        2'd2: full = int'(a & b);
        default: full = int'(~b);
      endcase
      res      = 16'(full);
      m_c      = res;
      m_status = {v, res[15], res == 16'h0};
      if (!(opc == 3'b101 && op == 2'b01)) m_reg[rd] = res;
      lat = 5;
    end else begin
      lat = 2;
      e   = 1'b1;
    end
  endtask

  task automatic read_reg(input int i, output logic [15:0] d);
    dbg_sel = 3'(i);
    #1;
    d = dbg_data;
  endtask

  task automatic check_regs(input string tag);
    logic [15:0] d;
    for (int i = 0; i < 8; i++) begin
      read_reg(i, d);
      check($sformatf("%s_r%0d", tag, i), 32'(d), 32'(m_reg[i]));
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"},  32'(instr_ready), 32'd1);
    check({tag, "_done"},   32'(done), 32'd0);
    check({tag, "_err"},    32'(err), 32'd0);
    check({tag, "_result"}, 32'(result), 32'(m_c));
    check({tag, "_status"}, 32'(status), 32'(m_status));
    check({tag, "_alu_in"}, {14'h0, alu_op, alu_ain}, 32'h0);
    check({tag, "_alu_b"},  32'(alu_bin), 32'h0);
    check_regs(tag);
  endtask

  // Accept one word, optionally hold junk on the input while busy, then
  // verify latency, pulses, busy behaviour and the architectural state.
  task automatic issue(input string tag, input logic [15:0] w, input bit junk);
    int lat, exp_lat, wcnt;
    bit exp_err, seen, busy_ok;
    wcnt = 0;
    while (!instr_ready && wcnt < 20) begin
      @(posedge clk); #1; wcnt++;
    end
    check({tag, "_ready_pre"}, 32'(instr_ready), 32'd1);
    @(negedge clk);
    instr = w;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    if (junk) instr = 16'($urandom);
    else      instr_valid = 1'b0;
    model_apply(w, exp_lat, exp_err);
    lat = 1;
    seen = done;
    busy_ok = !instr_ready && !err;
    while (!seen && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (instr_ready) busy_ok = 1'b0;
      if (done) seen = 1'b1;
      else if (err) busy_ok = 1'b0;
    end
    instr_valid = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err_pulse"}, 32'(err), 32'(exp_err));
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    @(posedge clk); #1;
    check_idle(tag);
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    int sel;
    w = 16'($urandom);
    sel = $urandom_range(0, 9);
    if (sel < 3)      w[15:11] = 5'b11010;
    else if (sel < 5) w[15:11] = 5'b11000;
    else if (sel < 9) w[15:13] = 3'b101;
    return w;
  endfunction

  initial begin
    logic [15:0] d;
    int lat;
    bit quiet;
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
    m_c = 16'h0;
    m_status = 3'b000;

    #12;
    check("rst_ready", 32'(instr_ready), 32'd1);
    check_idle("rst");
    @(negedge clk);
    rst_n = 1'b1;

    issue("movi_r0", 16'hD07F, 1'b0);
    issue("movi_r1", 16'hD180, 1'b1);
    read_reg(0, d); check("r0_7f", 32'(d), 32'h007F);
    read_reg(1, d); check("r1_ff80", 32'(d), 32'hFF80);
    check("movi_status", 32'(status), 32'd0);

    issue("movi_r1_1", 16'hD101, 1'b0);
    issue("mov_r2", 16'hC041, 1'b0);
    issue("add_r3", 16'hA16A, 1'b1);
    read_reg(3, d); check("r3_3", 32'(d), 32'h0003);
    check("add_status", 32'(status), 32'd0);

    issue("movi_r1_5", 16'hD105, 1'b0);
    issue("cmp_eq", 16'hA901, 1'b0);
    check("cmp_eq_status", 32'(status), 32'b001);
    check("cmp_eq_c", 32'(result), 32'h0);

    issue("movi_r6", 16'hD6FF, 1'b0);
    issue("mov_r5_lsr", 16'hC0B6, 1'b0);
    read_reg(5, d); check("r5_7fff", 32'(d), 32'h7FFF);
    issue("cmp_ovf", 16'hAD06, 1'b0);
    check("cmp_ovf_c", 32'(result), 32'h8000);
    check("cmp_ovf_status", 32'(status), 32'b110);

    issue("illegal", 16'hE000, 1'b0);

    for (int k = 0; k < 40; k++)
      issue($sformatf("rnd%0d", k), rand_word(), 1'($urandom_range(0, 1)));

    // Reset while ADD R4 is in EXEC: abort without writeback or done
    @(negedge clk);
    instr = 16'hA182;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    lat = 1;
    while (lat < 4) begin
      @(posedge clk); #1; lat++;
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
    m_c = 16'h0;
    m_status = 3'b000;
    check("arst_ready", 32'(instr_ready), 32'd1);
    check("arst_done", 32'(done), 32'd0);
    read_reg(4, d); check("arst_r4", 32'(d), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done || err || !instr_ready) quiet = 1'b0;
    end
    check("arst_no_done", 32'(quiet), 32'd1);
    check_idle("post_rst");
    issue("post_rst_movi", 16'hD4FE, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_sequencer.md
Name: alu_exec_sequencer

Overview:
- Multi-cycle execute stage wrapped around the 16-bit ALU (Ain, Bin, ALUop -> out, Z[2:0]).
- Accepts one 16-bit instruction word via valid/ready.
- Reads operands from an internal 8x16 register file into A/B holding registers, applies the shifter to B, and drives the external ALU.
- Captures the ALU result into C and the status flags into a status register, then writes the result back.

Parameters:
- DW, 16, datapath width; ALU is 16-bit, so only 16 is supported.
- NREG, 8, number of registers; register index is 3 bits.

Ports:
- clk in 1: single clock; all state updates on rising edge.
- rst_n in 1: asynchronous, active-low reset.
- instr_valid in 1: instruction word present.
- instr_ready out 1: high only in IDLE.
- instr in 16: instruction fields:
  - opcode = [15:13], op = [12:11], Rn = [10:8], Rd = [7:5], sh = [4:3], Rm = [2:0], imm8 = [7:0].
- alu_ain out 16: to ALU Ain.
- alu_bin out 16: to ALU Bin.
- alu_op out 2: to ALU ALUop.
- alu_out in 16: from ALU out.
- alu_z in 3: from ALU Z; bit0 = zero, bit1 = negative, bit2 = overflow.
- result out 16: C register.
- status out 3: status register.
- done out 1: one-cycle pulse at instruction completion.
- err out 1: one-cycle pulse, illegal instruction.
- dbg_sel in 3: register index for debug read.
- dbg_data out 16: R[dbg_sel], combinational.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE; R0..R7, A, B, C, status = 0; done = err = 0; instr_ready = 1.
  - A reset mid-instruction aborts it with no writeback.
- Handshake:
  - Accept on the rising edge where instr_valid && instr_ready; the word is latched into the IR.
  - instr_valid while busy is ignored; no queuing.
- Decoded instructions:
  - opcode 110, op 10: MOVI Rn <- sign_extend(imm8).
  - opcode 110, op 00: MOV Rd <- sh(Rm).
  - opcode 101, op 00: ADD Rd <- Rn + sh(Rm).
  - opcode 101, op 01: CMP, status <- Z of Rn - sh(Rm); no register write.
  - opcode 101, op 10: AND Rd <- Rn & sh(Rm).
  - opcode 101, op 11: MVN Rd <- ~sh(Rm).
  - Anything else is illegal.
- Shifter on B:
  - 00 = pass; 01 = shift left 1, lsb 0; 10 = logical shift right 1, msb 0; 11 = arithmetic shift right 1, msb kept.
- States: IDLE -> DECODE -> {WB_IMM | LOAD_A | ERR}.
  - LOAD_A (A <- R[Rn]) -> LOAD_B (B <- R[Rm]) -> EXEC -> WB -> IDLE.
  - MOV and MVN still pass through LOAD_A; A is unused.
- EXEC:
  - alu_ain = A for opcode 101, else 16'h0000.
  - alu_bin = sh(B).
  - alu_op = op for opcode 101, else 2'b00.
  - On the EXEC edge: C <- alu_out; status <- alu_z for every ALU-class instruction, including CMP.
  - Outside EXEC the ALU inputs hold 0.
- WB: R[Rd] <- C unless CMP; done = 1.
- WB_IMM: R[Rn] <- sign_extend(imm8); done = 1; C and status unchanged.
- ERR: done = 1, err = 1; no state change; return to IDLE.
- done and err are Moore outputs, high for exactly one cycle.
- Latency (cycle count after the accept edge, done high in that cycle):
  - MOVI: done in cycle 2.
  - ALU class: done in cycle 5.
  - Illegal: done in cycle 2.
  - The next instruction can be accepted in the cycle following done (IDLE).
- Rd = Rn or Rd = Rm is legal: operands are already latched in A and B before WB.
- Arithmetic wraps mod 2^16; overflow is reported only through alu_z[2].

Decomposition:
- Shared package holds:
  - Opcode constants OPC_MOV = 3'b110 and OPC_ALU = 3'b101.
  - ALU op constants ADD/CMP/AND/MVN.
  - Shift codes.
  - FSM state enum: IDLE, DECODE, LOAD_A, LOAD_B, EXEC, WB, WB_IMM, ERR.
  - Status bit indices Z = 0, N = 1, V = 2.
- One sub-module: regfile8x16 with one write port, two combinational read ports plus a debug read port, and async active-low clear.
- Shifter and decode remain inline. The ALU stays outside and is connected by the parent.

Test Plan:
- MOVI R0, #0x7F then MOVI R1, #0x80:
  - R0 = 0x007F and R1 = 0xFF80 via dbg.
  - done 2 cycles after each accept.
  - status stays 000.
- MOVI R1, #1, R2 = R1; then ADD R3, R1, R2, sh = 01:
  - R3 = 0x0003, status = 000, done on the 5th cycle after accept.
  - instr_ready low for the whole instruction.
- CMP R1, R1 with R1 = 5:
  - status = 001, C = 0, all registers unchanged.
- CMP with Rn = 0x7FFF, Rm = 0xFFFF:
  - Subtract overflows, C = 0x8000, status = 110 from the ALU.
- Illegal word 16'hE000:
  - err and done pulse together 2 cycles after accept; registers and status unchanged.
- Reset asserted during EXEC of ADD R4:
  - R4 = 0, state IDLE, instr_ready = 1 immediately (async).
  - No done pulse.
